// File: rtl/fp_wire.sv
// rtl/fp_wire.sv - shared fp_unit wire types and issue-arbiter request/state types
package fp_wire;

  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmsub;
    logic       fnmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fcmp;
    logic       fmax;
    logic       fclass;
    logic       fmv_i2f;
    logic       fmv_f2i;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
  } fp_arb_req_type;

  localparam fp_arb_req_type init_fp_arb_req = '{
    data1: 32'h0, data2: 32'h0, data3: 32'h0, fmt: 2'b0, rm: 3'b0, op: init_fp_operation
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fp_arb_state_type;

  // A request with no operation bit set needs no trip through fp_unit.
  function automatic logic op_is_none(input fp_operation_type op);
    return op == init_fp_operation;
  endfunction

endpackage

// File: rtl/fp_rr_pick.sv
// rtl/fp_rr_pick.sv - combinational round-robin picker starting at ptr
module fp_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);

  // Scan ascending from ptr with wrap; the first pending requester wins.
  always_comb begin
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/fp_issue_arbiter.sv
// rtl/fp_issue_arbiter.sv - round-robin, single-outstanding arbiter in front of fp_unit
module fp_issue_arbiter
  import fp_wire::*;
#(
  parameter int NREQ = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  fp_arb_req_type [NREQ-1:0]  req_i,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [31:0]                rsp_result,
  output logic [4:0]                 rsp_flags,
  output fp_exe_in_type              fp_exe_i,
  input  fp_exe_out_type             fp_exe_o
);

  localparam int PW = $clog2(NREQ);

  fp_arb_state_type state;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    ptr;
  fp_arb_req_type   req_q;
  logic [31:0]      result_q;
  logic [4:0]       flags_q;

  logic [NREQ-1:0]  pick_grant;
  logic [PW-1:0]    pick_idx;

  fp_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (pick_grant),
    .idx       (pick_idx)
  );

  // Grant is offered only while idle; held low during reset so nothing is accepted.
  assign req_ready = (state == IDLE && reset) ? pick_grant : '0;

  // Control FSM: accept, issue one enable, wait for fp_unit, hold response until taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      req_q    <= init_fp_arb_req;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick_grant) begin
            req_q <= req_i[pick_idx];
            owner <= pick_idx;
            if (op_is_none(req_i[pick_idx].op)) begin
              result_q <= '0;
              flags_q  <= '0;
              state    <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (fp_exe_o.ready) begin
            result_q <= fp_exe_o.result;
            flags_q  <= fp_exe_o.flags;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            ptr   <= (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response handshake is steered to the owner only.
  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

  // Execute port mirrors the latched request; enable pulses only in ISSUE.
  always_comb begin
    fp_exe_i.data1  = req_q.data1;
    fp_exe_i.data2  = req_q.data2;
    fp_exe_i.data3  = req_q.data3;
    fp_exe_i.fmt    = req_q.fmt;
    fp_exe_i.rm     = req_q.rm;
    fp_exe_i.op     = req_q.op;
    fp_exe_i.enable = (state == ISSUE);
  end

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// tb/tb_fp_issue_arbiter.sv - self-checking bench for fp_issue_arbiter
module tb_fp_issue_arbiter;
  import fp_wire::*;

  localparam int NREQ = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [NREQ-1:0]           req_valid = '0;
  fp_arb_req_type [NREQ-1:0] req_i     = '0;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           rsp_valid;
  logic [NREQ-1:0]           rsp_ready = '0;
  logic [31:0]               rsp_result;
  logic [4:0]                rsp_flags;
  fp_exe_in_type             fp_exe_i;
  fp_exe_out_type            fp_exe_o;

  fp_issue_arbiter #(.NREQ(NREQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_i      (req_i),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .fp_exe_i   (fp_exe_i),
    .fp_exe_o   (fp_exe_o)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic [4:0]  flags;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in fp_unit: known answers for the reference cases, a data mix otherwise.
  function automatic logic [36:0] unit_model(input logic [31:0] d1, input logic [31:0] d2,
                                             input logic [31:0] d3, input logic [2:0] rm,
                                             input fp_operation_type op);
    logic [31:0] opw;
    opw = '0;
    opw[$bits(fp_operation_type)-1:0] = op;
    if (op.fadd && d1 == 32'h3F800000 && d2 == 32'h40000000) return {32'h40400000, 5'h00};
    if (op.fdiv && d1 == 32'h3F800000 && d2 == 32'h00000000) return {32'h7F800000, 5'h08};
    if (op.fcvt_i2f && op.fcvt_op == 2'd0 && d1 == 32'hFFFFFFFF) return {32'hBF800000, 5'h00};
    return {d1 ^ {d2[15:0], d2[31:16]} ^ d3 ^ {29'b0, rm} ^ opw, d1[4:0] ^ d2[4:0]};
  endfunction

  int          unit_lat  = 1;
  int          unit_cnt  = 0;
  logic        unit_rdy  = 1'b0;
  logic        spurious  = 1'b0;
  logic [36:0] unit_out  = '0;
  int          en_count  = 0;
  int          overlap   = 0;

  always @(posedge clock) begin
    unit_rdy <= 1'b0;
    if (fp_exe_i.enable) begin
      en_count++;
      unit_out <= unit_model(fp_exe_i.data1, fp_exe_i.data2, fp_exe_i.data3, fp_exe_i.rm, fp_exe_i.op);
      unit_cnt <= unit_lat - 1;
      if (unit_lat == 1) unit_rdy <= 1'b1;
    end else if (unit_cnt > 0) begin
      unit_cnt <= unit_cnt - 1;
      if (unit_cnt == 1) unit_rdy <= 1'b1;
    end
  end

  always_comb begin
    fp_exe_o.result = unit_out[36:5];
    fp_exe_o.flags  = unit_out[4:0];
    fp_exe_o.ready  = unit_rdy | spurious;
  end

  always @(negedge clock) if (fp_exe_i.enable && rsp_valid != '0) overlap++;

  fp_operation_type op_add, op_sub, op_mul, op_div, op_cvt, op_none;

  typedef struct {
    int               idx;
    logic [31:0]      d1;
    logic [31:0]      d2;
    logic [31:0]      d3;
    logic [2:0]       rm;
    fp_operation_type op;
    logic [31:0]      er;
    logic [4:0]       ef;
    int               lat;
  } vec_t;
  vec_t vt[4];

  // One request from accept to response handshake, optionally with backpressure.
  task automatic do_req(input int idx, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] d3, input logic [2:0] rm, input fp_operation_type op,
                        input logic [31:0] er, input logic [4:0] ef, input int lat,
                        input int hold, input bit spur, input string name);
    bit   got;
    bit   zero;
    bit   bad;
    int   n;
    int   other;
    exp_t e;
    other    = 1 - idx;
    unit_lat = lat;
    req_i[idx] = '{data1: d1, data2: d2, data3: d3, fmt: 2'b0, rm: rm, op: op};
    req_valid[idx] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      #1;
      if (req_ready[idx]) got = 1'b1;
      else @(negedge clock);
    end
    check({name, " accept"}, 64'(got), 64'd1);
    if (!got) begin
      req_valid[idx] = 1'b0;
      return;
    end
    check({name, " grant"}, 64'(req_ready), 64'(1 << idx));
    sb.push_back('{idx: idx, res: er, flags: ef});
    zero = (op == init_fp_operation);
    @(negedge clock);
    req_valid[idx] = 1'b0;
    if (!zero) begin
      check({name, " enable"}, 64'(fp_exe_i.enable), 64'd1);
      check({name, " exe data"}, {fp_exe_i.data1, fp_exe_i.data2}, {d1, d2});
      if (spur) spurious = 1'b1;
    end
    n = 1;
    while (rsp_valid == '0 && n < 60) begin
      @(negedge clock);
      spurious = 1'b0;
      n++;
    end
    spurious = 1'b0;
    check({name, " latency"}, 64'(n), zero ? 64'd1 : 64'(lat + 2));
    check({name, " rsp_valid"}, 64'(rsp_valid), 64'(1 << idx));
    if (hold > 0) begin
      bad = 1'b0;
      req_i[other] = '{data1: 32'h11, data2: 32'h22, data3: 32'h0, fmt: 2'b0, rm: 3'b0, op: op_mul};
      req_valid[other] = 1'b1;
      rsp_ready[other] = 1'b1;
      for (int h = 0; h < hold; h++) begin
        #1;
        if (rsp_valid != NREQ'(1 << idx) || rsp_result != er || rsp_flags != ef || req_ready != '0)
          bad = 1'b1;
        @(negedge clock);
      end
      check({name, " held"}, 64'(bad), 64'd0);
      req_valid[other] = 1'b0;
      rsp_ready[other] = 1'b0;
    end
    if (sb.size() == 0) begin
      check({name, " scoreboard"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({name, " owner"}, 64'(rsp_valid), 64'(1 << e.idx));
      check({name, " result"}, {27'b0, rsp_result, rsp_flags}, {27'b0, e.res, e.flags});
    end
    rsp_ready[idx] = 1'b1;
    @(negedge clock);
    rsp_ready[idx] = 1'b0;
    check({name, " rsp drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int   grants;
    int   resps;
    int   g;
    int   gidx[4];
    int   en0;
    bit   bad;
    exp_t e;

    op_none = init_fp_operation;
    op_add = '0; op_add.fadd = 1'b1;
    op_sub = '0; op_sub.fsub = 1'b1;
    op_mul = '0; op_mul.fmul = 1'b1;
    op_div = '0; op_div.fdiv = 1'b1;
    op_cvt = '0; op_cvt.fcvt_i2f = 1'b1; op_cvt.fcvt_op = 2'd0;

    vt[0] = '{idx: 0, d1: 32'h3F800000, d2: 32'h40000000, d3: 32'h0, rm: 3'd0, op: op_add,
              er: 32'h40400000, ef: 5'h00, lat: 2};
    vt[1] = '{idx: 1, d1: 32'hFFFFFFFF, d2: 32'h0, d3: 32'h0, rm: 3'd0, op: op_cvt,
              er: 32'hBF800000, ef: 5'h00, lat: 1};
    vt[2] = '{idx: 0, d1: 32'h12345678, d2: 32'h9ABCDEF0, d3: 32'h0, rm: 3'd1, op: op_mul,
              er: 32'h0, ef: 5'h0, lat: 3};
    vt[3] = '{idx: 1, d1: 32'hCAFEF00D, d2: 32'h0BADBEEF, d3: 32'h5555AAAA, rm: 3'd3, op: op_sub,
              er: 32'h0, ef: 5'h0, lat: 4};
    for (int i = 2; i < 4; i++)
      {vt[i].er, vt[i].ef} = unit_model(vt[i].d1, vt[i].d2, vt[i].d3, vt[i].rm, vt[i].op);

    // Reset values, with a request pending during reset.
    req_valid = 2'b01;
    repeat (2) @(negedge clock);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp", {27'b0, rsp_result, rsp_flags}, 64'd0);
    check("reset exe_i", 64'(fp_exe_i == '0), 64'd1);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;

    // Both requesters continuously valid from reset release: grants alternate.
    unit_lat  = 1;
    req_i[0]  = '{data1: 32'hA0, data2: 32'hB0, data3: 32'h0, fmt: 2'b0, rm: 3'd0, op: op_mul};
    req_i[1]  = '{data1: 32'hA1, data2: 32'hB1, data3: 32'h0, fmt: 2'b0, rm: 3'd2, op: op_sub};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    grants = 0;
    resps  = 0;
    for (int c = 0; c < 80 && resps < 4; c++) begin
      if (grants == 4) req_valid = '0;
      #1;
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rr scoreboard", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          check("rr owner", 64'(rsp_valid), 64'(1 << e.idx));
          check("rr result", {27'b0, rsp_result, rsp_flags}, {27'b0, e.res, e.flags});
        end
        resps++;
      end
      if (req_ready != '0 && grants < 4) begin
        g = req_ready[1] ? 1 : 0;
        gidx[grants] = g;
        sb.push_back('{idx: g, res: unit_model(req_i[g].data1, req_i[g].data2, req_i[g].data3,
                                               req_i[g].rm, req_i[g].op) >> 5,
                       flags: unit_model(req_i[g].data1, req_i[g].data2, req_i[g].data3,
                                         req_i[g].rm, req_i[g].op) & 37'h1F});
        grants++;
      end
      @(negedge clock);
    end
    req_valid = '0;
    rsp_ready = '0;
    check("rr grant count", 64'(grants), 64'd4);
    check("rr resp count", 64'(resps), 64'd4);
    for (int k = 0; k < 4; k++) check($sformatf("rr order %0d", k), 64'(gidx[k]), 64'(k % 2));
    @(negedge clock);

    // Table of single operations, spurious ready injected in ISSUE on slow ones.
    for (int i = 0; i < 4; i++)
      do_req(vt[i].idx, vt[i].d1, vt[i].d2, vt[i].d3, vt[i].rm, vt[i].op, vt[i].er, vt[i].ef,
             vt[i].lat, 0, vt[i].lat >= 3, $sformatf("vec%0d", i));

    // Divide by zero held for 10 cycles under backpressure; req0 waits ungranted.
    do_req(1, 32'h3F800000, 32'h00000000, 32'h0, 3'd0, op_div, 32'h7F800000, 5'h08, 2, 10, 1'b0,
           "bp fdiv");

    // Zero operation with nonzero data: immediate zero response, no enable.
    en0 = en_count;
    do_req(1, 32'h1234, 32'h5678, 32'h9ABC, 3'd4, op_none, 32'h0, 5'h0, 1, 0, 1'b0, "zero op");
    check("zero op no enable", 64'(en_count - en0), 64'd0);

    // Reset while waiting on fp_unit: outputs clear at once, late ready ignored.
    unit_lat  = 20;
    req_i[0]  = '{data1: 32'h3F800000, data2: 32'h40000000, data3: 32'h0, fmt: 2'b0, rm: 3'd0,
                  op: op_add};
    req_valid = 2'b01;
    #1;
    check("mid accept", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = '0;
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("mid rst req_ready", 64'(req_ready), 64'd0);
    check("mid rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid rst rsp", {27'b0, rsp_result, rsp_flags}, 64'd0);
    check("mid rst exe_i", 64'(fp_exe_i == '0), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (rsp_valid != '0 || fp_exe_i.enable) bad = 1'b1;
      @(negedge clock);
    end
    check("mid rst no stale rsp", 64'(bad), 64'd0);

    check("enable overlap", 64'(overlap), 64'd0);
    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
